// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a ready/valid input handshake.
//
// Frame on TX_OUT: start (0), DATA_WIDTH data bits LSB first, optional parity bit,
// then one or two stop bits (1). Every bit lasts CLKS_PER_BIT clocks. The line
// idles high.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high; aborts any frame and drops stored words
//   P_DATA     in   frame data (DATA_WIDTH bits)
//   DATA_VALID in   producer offers P_DATA together with PAR_EN/PAR_TYP/STOP2
//   DATA_READY out  word is accepted on this rising edge if DATA_VALID is also high
//   PAR_EN     in   1 = append a parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   STOP2      in   1 = two stop bits
//   TX_OUT     out  registered serial line
//   Busy       out  registered, high while a frame is on the line
//
// Optional build macro UART_TX_FIFO_EN: replaces the single holding register with
// a FIFO_DEPTH-entry input FIFO so frames can be chained without idle gaps.

module uart_tx_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int unsigned       BIT_W     = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // One accepted word together with the frame options captured alongside it.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
  } word_t;

  function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic odd);
    parity_f = (^d) ^ odd;
  endfunction

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;      // data bit index, reused as stop-bit index
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;  // remaining data bits, bit 0 is on the line
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  word_t                 in_word_s;
  word_t                 next_word_s;       // word loaded when a frame starts
  logic                  next_avail_s;      // a word is available to start a frame
  logic                  load_s;
  logic                  pop_s;
  logic                  bit_end_s;

  assign in_word_s = {P_DATA, PAR_EN, PAR_TYP, STOP2};
  assign bit_end_s = (baud_q == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic        CHAIN_EN = 1'b1;

  word_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              push_s;

  // Ready depends on the registered full flag only, so a same-cycle pop never frees a slot.
  assign DATA_READY   = !full_q && !reset;
  assign push_s       = DATA_VALID && DATA_READY;
  assign next_avail_s = (count_q != {CNT_W{1'b0}});
  assign next_word_s  = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // FIFO storage; entries are only read while counted as valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_word_s;
    end
  end
`else
  localparam logic CHAIN_EN = 1'b0;

  // Holding register is the frame register itself; a word is taken only from IDLE.
  assign DATA_READY   = (state_q == S_IDLE) && !reset;
  assign next_avail_s = DATA_VALID;
  assign next_word_s  = in_word_s;

  // FIFO_DEPTH and the pop strobe have no role in this build.
  logic unused_fifo_s;
  assign unused_fifo_s = pop_s & (FIFO_DEPTH != 32'd0);
`endif

  // Frame FSM next-state, bit timing and registered-output next values.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    load_s    = 1'b0;
    pop_s     = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (next_avail_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
        end else begin
          baud_d  = baud_q + BAUD_W'(1'b1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_d  = {BAUD_W{1'b0}};
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = {BIT_W{1'b0}};
            if (par_en_q) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1'b1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
        end else begin
          baud_d  = baud_q + BAUD_W'(1'b1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_d = {BAUD_W{1'b0}};
          if (stop2_q && (bit_q == {BIT_W{1'b0}})) begin
            bit_d = BIT_W'(1'b1);
          end else if (CHAIN_EN && next_avail_s) begin
            // Chain straight into the next start bit with no idle cycle.
            load_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            bit_d   = {BIT_W{1'b0}};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_s) begin
      pop_s     = 1'b1;
      state_d   = S_START;
      baud_d    = {BAUD_W{1'b0}};
      bit_d     = {BIT_W{1'b0}};
      shreg_d   = next_word_s.data;
      par_en_d  = next_word_s.par_en;
      par_bit_d = parity_f(next_word_s.data, next_word_s.par_typ);
      stop2_d   = next_word_s.stop2;
    end else begin
      pop_s     = 1'b0;
    end

    // Outputs are registered from the next state so they switch on the same edge.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_bit_d;
      S_STOP:   tx_d = 1'b1;
      S_IDLE:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Frame FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= {BAUD_W{1'b0}};
      bit_q     <= {BIT_W{1'b0}};
      shreg_q   <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
